// File: rtl/wb_arbiter_pkg.sv
// Shared types and configuration for the writeback arbiter.
//   creg_addr_t : architectural register address (32 registers)
//   u64         : 64-bit result value
//   wb_req_t    : one buffered writeback request {rd, data}
package wb_arbiter_pkg;

  localparam int WB_SRC_PORTS     = 3;  // ALU, MEM, MUL/DIV
  localparam int WB_FIFO_DEPTH    = 2;  // entries per source FIFO
  localparam int AREG_WRITE_PORTS = 2;  // regfile write ports
  localparam int CREG_ADDR_W      = 5;

  typedef logic [CREG_ADDR_W-1:0] creg_addr_t;
  typedef logic [63:0]            u64;

  typedef struct packed {
    creg_addr_t rd;
    u64         data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-source writeback FIFO.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   push_i/push_data_i  : enqueue request (ignored when full)
//   pop_i               : dequeue head (ignored when empty)
//   head_o              : current head entry
//   full_o/empty_o      : occupancy flags
//   count_o             : number of valid entries
//   ent_valid_o/ent_rd_o: flat per-slot valid/rd view for the pending bitmap
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_req_t                push_data_i,
  input  logic                   pop_i,
  output wb_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [PW:0]            count_o,
  output logic [DEPTH-1:0]       ent_valid_o,
  output creg_addr_t [DEPTH-1:0] ent_rd_o
);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses a push even if it pops at the same edge.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity,
  // and leaving the array reset-free lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Slot e is valid when its distance from the read pointer is below count.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      ent_valid_o[e] = ({1'b0, PW'(e) - rd_ptr_q} < count_q);
      ent_rd_o[e]    = mem_q[e].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from SRC_PORTS producers in per-source
// FIFOs and grants up to WRITE_PORTS of them per cycle, round-robin, onto
// registered regfile write ports.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   src_valid_i/ready_o   : per-source valid/ready handshake
//   src_rd_i/src_data_i   : per-source destination register and value
//   wa_o/wvalid_o/wd_o    : registered regfile write ports
//   pending_o             : bit r set while a write to r is buffered or issued
//   idle_o                : nothing buffered and no write issued
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int SRC_PORTS   = WB_SRC_PORTS,
  parameter int WRITE_PORTS = AREG_WRITE_PORTS,
  parameter int DEPTH       = WB_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic       [SRC_PORTS-1:0]   src_valid_i,
  output logic       [SRC_PORTS-1:0]   src_ready_o,
  input  creg_addr_t [SRC_PORTS-1:0]   src_rd_i,
  input  u64         [SRC_PORTS-1:0]   src_data_i,
  output creg_addr_t [WRITE_PORTS-1:0] wa_o,
  output logic       [WRITE_PORTS-1:0] wvalid_o,
  output u64         [WRITE_PORTS-1:0] wd_o,
  output logic       [31:0]            pending_o,
  output logic                         idle_o
);

  localparam int SW = (SRC_PORTS > 1) ? $clog2(SRC_PORTS) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_req_t                push_req   [SRC_PORTS];
  wb_req_t    [SRC_PORTS-1:0] head;
  logic       [SRC_PORTS-1:0] push;
  logic       [SRC_PORTS-1:0] pop;
  logic       [SRC_PORTS-1:0] fifo_full;
  logic       [SRC_PORTS-1:0] fifo_empty;
  logic       [CW-1:0]        fifo_count [SRC_PORTS];
  logic       [DEPTH-1:0]     ent_valid  [SRC_PORTS];
  creg_addr_t [DEPTH-1:0]     ent_rd     [SRC_PORTS];

  creg_addr_t [WRITE_PORTS-1:0] wa_q, wa_d;
  u64         [WRITE_PORTS-1:0] wd_q, wd_d;
  logic       [WRITE_PORTS-1:0] wvalid_q, wvalid_d;
  logic       [SW-1:0]          rr_q, rr_d;
  int                           n_grant;
  logic                         dup;

  for (genvar g = 0; g < SRC_PORTS; g++) begin : g_src
    // Ready depends only on occupancy, never on src_valid_i.
    assign src_ready_o[g] = (fifo_count[g] < CW'(DEPTH));
    // Writes to r0 complete the handshake but are dropped.
    assign push[g]        = src_valid_i[g] & ~fifo_full[g] & (src_rd_i[g] != '0);
    assign push_req[g]    = '{rd: src_rd_i[g], data: src_data_i[g]};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push[g]),
      .push_data_i(push_req[g]),
      .pop_i      (pop[g]),
      .head_o     (head[g]),
      .full_o     (fifo_full[g]),
      .empty_o    (fifo_empty[g]),
      .count_o    (fifo_count[g]),
      .ent_valid_o(ent_valid[g]),
      .ent_rd_o   (ent_rd[g])
    );
  end

  // Round-robin scan from rr_q; the k-th winner goes to slot k. A head whose
  // rd matches an earlier grant this cycle waits, so no slot pair collides.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wa_d     = wa_q;
    wd_d     = wd_q;
    wvalid_d = '0;
    pop      = '0;
    rr_d     = rr_q;
    n_grant  = 0;
    dup      = 1'b0;
    for (int i = 0; i < SRC_PORTS; i++) begin
      for (int j = 0; j < SRC_PORTS; j++) begin
        if (j == (int'(rr_q) + i) % SRC_PORTS) begin
          dup = 1'b0;
          for (int k = 0; k < WRITE_PORTS; k++) begin
            if (k < n_grant && wa_d[k] == head[j].rd) dup = 1'b1;
          end
          if (!fifo_empty[j] && n_grant < WRITE_PORTS && !dup) begin
            for (int k = 0; k < WRITE_PORTS; k++) begin
              if (k == n_grant) begin
                wa_d[k]     = head[j].rd;
                wd_d[k]     = head[j].data;
                wvalid_d[k] = 1'b1;
              end
            end
            pop[j]  = 1'b1;
            rr_d    = SW'((j + 1) % SRC_PORTS);
            n_grant = n_grant + 1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q     <= '0;
      wd_q     <= '0;
      wvalid_q <= '0;
      rr_q     <= '0;
    end else begin
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      wvalid_q <= wvalid_d;
      rr_q     <= rr_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int s = 0; s < SRC_PORTS; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_valid[s][e]) pending_o[ent_rd[s][e]] = 1'b1;
      end
    end
    for (int k = 0; k < WRITE_PORTS; k++) begin
      if (wvalid_q[k]) pending_o[wa_q[k]] = 1'b1;
    end
    pending_o[0] = 1'b0;
  end

  assign wa_o     = wa_q;
  assign wd_o     = wd_q;
  assign wvalid_o = wvalid_q;
  assign idle_o   = (&fifo_empty) & ~(|wvalid_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter (3 sources, 2 write ports, depth 2).
// Each accepted result is queued per source; the monitor pops and compares
// on every issued write. Source id travels in wd[63:56].
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NS = WB_SRC_PORTS;
  localparam int NW = AREG_WRITE_PORTS;

  logic                  clk;
  logic                  rst_n;
  logic       [NS-1:0]   src_valid;
  logic       [NS-1:0]   src_ready;
  creg_addr_t [NS-1:0]   src_rd;
  u64         [NS-1:0]   src_data;
  creg_addr_t [NW-1:0]   wa;
  logic       [NW-1:0]   wvalid;
  u64         [NW-1:0]   wd;
  logic       [31:0]     pending;
  logic                  idle;

  int      n_cmp = 0;
  int      n_err = 0;
  wb_req_t exp_q [NS][$];
  int      mon_s;
  wb_req_t mon_e;
  int      seq = 0;

  wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .src_rd_i   (src_rd),
    .src_data_i (src_data),
    .wa_o       (wa),
    .wvalid_o   (wvalid),
    .wd_o       (wd),
    .pending_o  (pending),
    .idle_o     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic u64 tag(input int s, input int v);
    return {8'(s), 56'(v)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Record handshakes for the current inputs, then advance to the next negedge.
  task automatic cycle();
    wb_req_t r;
    for (int s = 0; s < NS; s++) begin
      if (src_valid[s] && src_ready[s] && src_rd[s] != '0) begin
        r.rd   = src_rd[s];
        r.data = src_data[s];
        exp_q[s].push_back(r);
      end
    end
    @(negedge clk);
  endtask

  // Monitor: every issued write must match its source's oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pending_r0", 64'(pending[0]), 64'(0));
      if (wvalid[1]) check("slot_compact", 64'(wvalid[0]), 64'(1));
      if (wvalid == 2'b11) check("same_cycle_dup", 64'(wa[0] != wa[1]), 64'(1));
      for (int k = 0; k < NW; k++) begin
        if (wvalid[k]) begin
          mon_s = int'(wd[k][63:56]);
          if (mon_s >= NS || exp_q[mon_s].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write slot%0d: got wa=%0d wd=0x%0h, expected no write",
                     k, wa[k], wd[k]);
          end else begin
            mon_e = exp_q[mon_s].pop_front();
            check("wb_rd", 64'(wa[k]), 64'(mon_e.rd));
            check("wb_data", wd[k], mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    #12;
    check("rst_wvalid", 64'(wvalid), 64'(0));
    check("rst_wa", 64'(wa), 64'(0));
    check("rst_wd", 64'(wd), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 64'(src_ready), 64'(3'b111));
    @(negedge clk);

    // Single ALU result: rd=5, 0x11; two-cycle latency.
    src_valid    = 3'b001;
    src_rd[0]    = 5'd5;
    src_data[0]  = tag(0, 'h11);
    cycle();
    src_valid = '0;
    check("lat_c1_wvalid", 64'(wvalid), 64'(0));
    check("lat_c1_pend5", 64'(pending[5]), 64'(1));
    cycle();
    check("lat_c2_wvalid", 64'(wvalid), 64'(2'b01));
    check("lat_c2_wa", 64'(wa[0]), 64'(5));
    check("lat_c2_wd", wd[0], 64'h11);
    check("lat_c2_pend5", 64'(pending[5]), 64'(1));
    cycle();
    check("lat_c3_wvalid", 64'(wvalid), 64'(0));
    check("lat_c3_pend5", 64'(pending[5]), 64'(0));
    check("lat_c3_idle", 64'(idle), 64'(1));

    // MEM and MUL both rd=7 with rr at MEM: MEM first, MUL the cycle after.
    src_valid   = 3'b110;
    src_rd[1]   = 5'd7;
    src_data[1] = tag(1, 'hA);
    src_rd[2]   = 5'd7;
    src_data[2] = tag(2, 'hB);
    cycle();
    src_valid = '0;
    check("dup_pend7", 64'(pending[7]), 64'(1));
    cycle();
    check("dup_c2_wvalid", 64'(wvalid), 64'(2'b01));
    check("dup_c2_wa", 64'(wa[0]), 64'(7));
    check("dup_c2_wd", wd[0], 64'h0100_0000_0000_000A);
    cycle();
    check("dup_c3_wvalid", 64'(wvalid), 64'(2'b01));
    check("dup_c3_wd", wd[0], 64'h0200_0000_0000_000B);
    cycle();
    check("dup_c4_idle", 64'(idle), 64'(1));

    // rd=0: accepted, never written.
    src_valid   = 3'b001;
    src_rd[0]   = 5'd0;
    src_data[0] = tag(0, 'hDEAD);
    check("r0_ready", 64'(src_ready[0]), 64'(1));
    cycle();
    src_valid = '0;
    check("r0_idle", 64'(idle), 64'(1));
    check("r0_pending", 64'(pending), 64'(0));
    check("r0_ready_after", 64'(src_ready), 64'(3'b111));
    for (int c = 0; c < 2; c++) begin
      cycle();
      check("r0_wvalid", 64'(wvalid), 64'(0));
    end

    // ALU and MEM held valid with rd=9: shared rd drains one per cycle, so
    // the FIFOs alternate full; a full FIFO that pops stays not-ready that cycle.
    src_valid = 3'b011;
    src_rd[0] = 5'd9;
    src_rd[1] = 5'd9;
    for (int n = 0; n < 5; n++) begin
      src_data[0] = tag(0, 100 + n);
      src_data[1] = tag(1, 200 + n);
      cycle();
      case (n)
        0: check("full_e1_ready", 64'(src_ready), 64'(3'b111));
        1: check("full_e2_ready", 64'(src_ready), 64'(3'b101));
        2: check("full_e3_ready", 64'(src_ready), 64'(3'b110));
        3: check("full_e4_ready", 64'(src_ready), 64'(3'b101));
        default: check("full_e5_ready", 64'(src_ready), 64'(3'b110));
      endcase
    end
    check("pre_rst_wvalid", 64'(wvalid), 64'(2'b01));
    check("pre_rst_pend9", 64'(pending[9]), 64'(1));

    // Mid-cycle async reset with ALU holding two entries.
    src_valid = '0;
    #2;
    rst_n = 1'b0;
    for (int s = 0; s < NS; s++) exp_q[s].delete();
    #1;
    check("midrst_wvalid", 64'(wvalid), 64'(0));
    check("midrst_pending", 64'(pending), 64'(0));
    check("midrst_idle", 64'(idle), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready", 64'(src_ready), 64'(3'b111));
    check("midrst_idle_after", 64'(idle), 64'(1));
    @(negedge clk);

    // Random traffic with colliding rds (including r0) against the scoreboard.
    for (int c = 0; c < 100; c++) begin
      for (int s = 0; s < NS; s++) begin
        src_valid[s] = ($urandom_range(0, 99) < 70);
        src_rd[s]    = creg_addr_t'($urandom_range(0, 3));
        src_data[s]  = tag(s, seq);
        seq++;
      end
      cycle();
    end
    src_valid = '0;
    for (int c = 0; c < 20 && !idle; c++) cycle();
    check("drain_idle", 64'(idle), 64'(1));
    for (int s = 0; s < NS; s++) check("drain_sb_empty", 64'(exp_q[s].size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
